// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S target-mode receive path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package i2s_pkg;

    localparam int DATA_WIDTH_DEF = 32;

    // Word-select level for each channel on the wire.
    localparam logic WS_LEFT  = 1'b0;
    localparam logic WS_RIGHT = 1'b1;

    // Frame alignment state of the receiver.
    typedef enum logic [1:0] {
        RX_UNLOCKED = 2'd0,
        RX_LEFT     = 2'd1,
        RX_RIGHT    = 2'd2
    } rx_state_e;

endpackage

// File: rtl/i2s_sync_edge.sv
// Synchronizes external sck/ws/sd into clk and flags each sck rising edge.
// Latency: SYNC_STAGES clk to the synced values; sck_rise is combinational from them.
// Backpressure: none; it follows the external master unconditionally.
module i2s_sync_edge #(
    parameter int SYNC_STAGES = 2  // must be at least 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic sck,
    input  logic ws,
    input  logic sd,
    output logic sck_rise,
    output logic ws_s,
    output logic sd_s
);

    logic [SYNC_STAGES-1:0] sck_pipe_q, sck_pipe_d;
    logic [SYNC_STAGES-1:0] ws_pipe_q,  ws_pipe_d;
    logic [SYNC_STAGES-1:0] sd_pipe_q,  sd_pipe_d;
    logic                   sck_prev_q, sck_prev_d;

    // Shift each pin one stage deeper; remember the last synced sck for edge detection.
    always_comb begin
        sck_pipe_d = {sck_pipe_q[SYNC_STAGES-2:0], sck};
        ws_pipe_d  = {ws_pipe_q[SYNC_STAGES-2:0],  ws};
        sd_pipe_d  = {sd_pipe_q[SYNC_STAGES-2:0],  sd};
        sck_prev_d = sck_pipe_q[SYNC_STAGES-1];
    end

    // Synchronizer and edge-history flops.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sck_pipe_q <= '0;
            ws_pipe_q  <= '0;
            sd_pipe_q  <= '0;
            sck_prev_q <= 1'b0;
        end else begin
            sck_pipe_q <= sck_pipe_d;
            ws_pipe_q  <= ws_pipe_d;
            sd_pipe_q  <= sd_pipe_d;
            sck_prev_q <= sck_prev_d;
        end
    end

    assign sck_rise = sck_pipe_q[SYNC_STAGES-1] & ~sck_prev_q;
    assign ws_s     = ws_pipe_q[SYNC_STAGES-1];
    assign sd_s     = sd_pipe_q[SYNC_STAGES-1];

endmodule

// File: rtl/i2s_target_receive.sv
// I2S target-mode receiver: deserializes sd into {left, right} frames on valid/ready.
// Latency: frame valid 3-4 clk after the pin sck rise carrying the right LSB (2 sync stages).
// Backpressure: a frame completing while the output is held is dropped with a 1-clk overrun pulse.
module i2s_target_receive
    import i2s_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  sck,
    input  logic                  ws,
    input  logic                  sd,
    output logic [DATA_WIDTH-1:0] data_left,
    output logic [DATA_WIDTH-1:0] data_right,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  overrun
);

    localparam int              CW      = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(DATA_WIDTH);

    logic sck_rise, ws_s, sd_s;

    i2s_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .resetn  (resetn),
        .sck     (sck),
        .ws      (ws),
        .sd      (sd),
        .sck_rise(sck_rise),
        .ws_s    (ws_s),
        .sd_s    (sd_s)
    );

    rx_state_e             state_q,      state_d;
    logic                  ws_prev_q,    ws_prev_d;
    logic [CW-1:0]         cnt_q,        cnt_d;
    logic [DATA_WIDTH-1:0] word_q,       word_d;
    logic [DATA_WIDTH-1:0] left_hold_q,  left_hold_d;
    logic [DATA_WIDTH-1:0] data_left_q,  data_left_d;
    logic [DATA_WIDTH-1:0] data_right_q, data_right_d;
    logic                  out_valid_q,  out_valid_d;
    logic                  overrun_q,    overrun_d;

    logic [DATA_WIDTH-1:0] word_bits;   // working word including this rise's bit
    logic                  frame_done;

    // Bit capture, word close, frame alignment and output handshake, all advanced on sck rises.
    always_comb begin
        state_d      = state_q;
        ws_prev_d    = ws_prev_q;
        cnt_d        = cnt_q;
        word_d       = word_q;
        left_hold_d  = left_hold_q;
        data_left_d  = data_left_q;
        data_right_d = data_right_q;
        out_valid_d  = out_valid_q;
        overrun_d    = 1'b0;
        word_bits    = word_q;
        frame_done   = 1'b0;

        if (sck_rise) begin
            // Bits beyond DATA_WIDTH are dropped; the counter parks at DATA_WIDTH.
            if (cnt_q < CNT_MAX) begin
                for (int i = 0; i < DATA_WIDTH; i++) begin
                    if (cnt_q == CW'(DATA_WIDTH - 1 - i)) begin
                        word_bits[i] = sd_s;
                    end
                end
                cnt_d = cnt_q + CW'(1);
            end
            word_d    = word_bits;
            ws_prev_d = ws_s;

            // A ws change marks this rise's bit as the LSB of the closing word.
            if (ws_s != ws_prev_q) begin
                word_d = '0;
                cnt_d  = '0;
                // Once locked, ws_prev tracks the channel, so LEFT only sees 0->1
                // and RIGHT only sees 1->0 boundaries.
                case (state_q)
                    RX_UNLOCKED: if (ws_s == WS_LEFT) state_d = RX_LEFT;
                    RX_LEFT: begin
                        left_hold_d = word_bits;
                        state_d     = RX_RIGHT;
                    end
                    RX_RIGHT: begin
                        frame_done = 1'b1;
                        state_d    = RX_LEFT;
                    end
                    default: state_d = RX_UNLOCKED;
                endcase
            end
        end

        if (frame_done) begin
            if (!out_valid_q || out_ready) begin
                data_left_d  = left_hold_q;
                data_right_d = word_bits;
                out_valid_d  = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= RX_UNLOCKED;
            ws_prev_q    <= 1'b0;
            cnt_q        <= '0;
            word_q       <= '0;
            left_hold_q  <= '0;
            data_left_q  <= '0;
            data_right_q <= '0;
            out_valid_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ws_prev_q    <= ws_prev_d;
            cnt_q        <= cnt_d;
            word_q       <= word_d;
            left_hold_q  <= left_hold_d;
            data_left_q  <= data_left_d;
            data_right_q <= data_right_d;
            out_valid_q  <= out_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign data_left  = data_left_q;
    assign data_right = data_right_q;
    assign out_valid  = out_valid_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_i2s_target_receive.sv
// Bench for i2s_target_receive: drives an I2S master stream and checks frames
// against a run-based model of the word stream.
// clk period 20, sck period 160 (clk/8).
module tb_i2s_target_receive;

    logic        clk, resetn, sck, ws, sd, out_ready, out_valid, overrun;
    logic [31:0] data_left, data_right;

    int n_checks = 0;
    int n_errors = 0;
    int ovr_cnt  = 0;

    logic [63:0] acc_q[$];   // frames accepted by the consumer
    logic [63:0] exp_q[$];   // frames predicted by the model
    bit          sd_q[$];    // per-sck-slot data bit
    bit          ch_q[$];    // per-sck-slot channel (0 left, 1 right)

    i2s_target_receive #(
        .DATA_WIDTH (32),
        .SYNC_STAGES(2)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .sck       (sck),
        .ws        (ws),
        .sd        (sd),
        .data_left (data_left),
        .data_right(data_right),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun   (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // Consumer-side monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (resetn) begin
            if (out_valid && out_ready) acc_q.push_back({data_left, data_right});
            if (overrun) ovr_cnt++;
        end
    end

    task automatic new_stream();
        sd_q.delete();
        ch_q.delete();
    endtask

    // Append one word, MSB first, occupying nbits sck slots of channel ch.
    task automatic add_word(input bit ch, input logic [63:0] val, input int nbits);
        for (int b = nbits - 1; b >= 0; b--) begin
            sd_q.push_back(val[b]);
            ch_q.push_back(ch);
        end
    endtask

    // Model: split slots into runs of equal channel; each run is one word, left-justified
    // or truncated to 32 bits. A frame is a left run followed by a right run, where the
    // left run is not the first (pre-lock partial) and the right run is closed by a later run.
    task automatic build_expected(input int start);
        bit          rch[$];
        logic [31:0] rw[$];
        logic [63:0] v;
        int          len;
        int          j;
        bit          c;
        exp_q.delete();
        j = start;
        while (j < sd_q.size()) begin
            c   = ch_q[j];
            v   = '0;
            len = 0;
            while (j < sd_q.size() && ch_q[j] == c) begin
                v = (v << 1) | 64'(sd_q[j]);
                len++;
                j++;
            end
            rch.push_back(c);
            rw.push_back(len >= 32 ? 32'(v >> (len - 32)) : 32'(v << (32 - len)));
        end
        for (int i = 1; i + 2 < rch.size(); i++) begin
            if (rch[i] == 1'b0 && rch[i+1] == 1'b1) exp_q.push_back({rw[i], rw[i+1]});
        end
    endtask

    // I2S master: ws and sd change while sck is low; ws leads the data by one slot.
    task automatic play();
        for (int j = 0; j < sd_q.size(); j++) begin
            ws = (j + 1 < sd_q.size()) ? ch_q[j+1] : ch_q[j];
            sd = sd_q[j];
            #80 sck = 1'b1;
            #80 sck = 1'b0;
        end
    endtask

    // Start streams 3 time units after a clk rise so every sck rise has a fixed clk phase.
    task automatic align(output time t0);
        @(posedge clk);
        #3;
        t0 = $time;
    endtask

    task automatic idle();
        repeat (12) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn    = 1'b0;
        out_ready = 1'b0;
        sck       = 1'b0;
        ws        = 1'b0;
        sd        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        resetn = 1'b1;
        acc_q.delete();
        ovr_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        n_checks++;
        if (overrun !== 1'b0) begin n_errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        n_checks++;
        if (data_left !== 32'h0) begin n_errors++; $display("FAIL reset_left: got %h expected 0", data_left); end
        n_checks++;
        if (data_right !== 32'h0) begin n_errors++; $display("FAIL reset_right: got %h expected 0", data_right); end
        release_reset();
        idle();
        n_checks++;
        if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_idle_valid: got %b expected 0", out_valid); end
    endtask

    task automatic test_lock();
        time t0, tr;
        do_reset();
        release_reset();
        out_ready = 1'b1;
        new_stream();
        add_word(1'b1, 64'($urandom), 13);
        add_word(1'b0, 64'hA5A50F0F, 32);
        add_word(1'b1, 64'h12345678, 32);
        add_word(1'b0, 64'($urandom), 4);
        build_expected(0);
        align(t0);
        tr = t0 + 80 + 160 * 76;   // rise carrying the right-word LSB
        fork
            play();
            begin
                #(tr + 47 - $time);
                n_checks++;
                if (out_valid !== 1'b0) begin n_errors++; $display("FAIL lock_latency_early: got %b expected 0", out_valid); end
                #20;
                n_checks++;
                if (out_valid !== 1'b1) begin n_errors++; $display("FAIL lock_latency: got %b expected 1", out_valid); end
            end
        join
        idle();
        n_checks++;
        if (acc_q.size() !== 1) begin n_errors++; $display("FAIL lock_count: got %0d expected 1", acc_q.size()); end
        n_checks++;
        if (acc_q.size() < 1 || acc_q[0] !== 64'hA5A50F0F_12345678) begin
            n_errors++;
            $display("FAIL lock_frame: got %h expected %h", (acc_q.size() > 0) ? acc_q[0] : 64'hx, 64'hA5A50F0F_12345678);
        end
        n_checks++;
        if (exp_q.size() < 1 || acc_q.size() < 1 || acc_q[0] !== exp_q[0]) begin
            n_errors++;
            $display("FAIL lock_model: got %0d frames, model has %0d", acc_q.size(), exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        release_reset();
        new_stream();
        add_word(1'b1, 64'($urandom), 5);
        add_word(1'b0, 64'h11111111, 32);
        add_word(1'b1, 64'h22222222, 32);
        add_word(1'b0, 64'h33333333, 32);
        add_word(1'b1, 64'h44444444, 32);
        add_word(1'b0, 64'($urandom), 3);
        build_expected(0);
        play();
        idle();
        n_checks++;
        if (out_valid !== 1'b1) begin n_errors++; $display("FAIL bp_valid: got %b expected 1", out_valid); end
        n_checks++;
        if ({data_left, data_right} !== exp_q[0]) begin n_errors++; $display("FAIL bp_held: got %h expected %h", {data_left, data_right}, exp_q[0]); end
        n_checks++;
        if (ovr_cnt !== exp_q.size() - 1) begin n_errors++; $display("FAIL bp_overrun: got %0d expected %0d", ovr_cnt, exp_q.size() - 1); end
        n_checks++;
        if (acc_q.size() !== 0) begin n_errors++; $display("FAIL bp_no_accept: got %0d expected 0", acc_q.size()); end
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (acc_q.size() !== 1 || acc_q[0] !== 64'h11111111_22222222) begin
            n_errors++;
            $display("FAIL bp_accept: got %0d frames, first %h expected %h", acc_q.size(), (acc_q.size() > 0) ? acc_q[0] : 64'hx, 64'h11111111_22222222);
        end
        n_checks++;
        if (out_valid !== 1'b0) begin n_errors++; $display("FAIL bp_valid_drop: got %b expected 0", out_valid); end
        n_checks++;
        if (data_left !== 32'h11111111) begin n_errors++; $display("FAIL bp_data_held_after: got %h expected %h", data_left, 32'h11111111); end
    endtask

    task automatic test_short_words();
        do_reset();
        release_reset();
        out_ready = 1'b1;
        new_stream();
        add_word(1'b1, 64'($urandom), 7);
        add_word(1'b0, 64'hABCDEF, 24);
        add_word(1'b1, 64'h123456, 24);
        add_word(1'b0, 64'($urandom), 24);
        build_expected(0);
        play();
        idle();
        n_checks++;
        if (acc_q.size() !== 1) begin n_errors++; $display("FAIL short_count: got %0d expected 1", acc_q.size()); end
        n_checks++;
        if (acc_q.size() < 1 || acc_q[0] !== 64'hABCDEF00_12345600) begin
            n_errors++;
            $display("FAIL short_frame: got %h expected %h", (acc_q.size() > 0) ? acc_q[0] : 64'hx, 64'hABCDEF00_12345600);
        end
    endtask

    task automatic test_long_words();
        logic [63:0] rv;
        do_reset();
        release_reset();
        out_ready = 1'b1;
        rv = {$urandom, $urandom};
        new_stream();
        add_word(1'b1, 64'($urandom), 6);
        add_word(1'b0, {24'h0, 32'hDEADBEEF, 8'($urandom)}, 40);
        add_word(1'b1, rv, 40);
        add_word(1'b0, 64'($urandom), 40);
        build_expected(0);
        play();
        idle();
        n_checks++;
        if (acc_q.size() !== 1) begin n_errors++; $display("FAIL long_count: got %0d expected 1", acc_q.size()); end
        n_checks++;
        if (acc_q.size() < 1 || acc_q[0][63:32] !== 32'hDEADBEEF) begin
            n_errors++;
            $display("FAIL long_left: got %h expected %h", (acc_q.size() > 0) ? acc_q[0][63:32] : 32'hx, 32'hDEADBEEF);
        end
        n_checks++;
        if (acc_q.size() < 1 || acc_q[0][31:0] !== rv[39:8]) begin
            n_errors++;
            $display("FAIL long_right: got %h expected %h", (acc_q.size() > 0) ? acc_q[0][31:0] : 32'hx, rv[39:8]);
        end
    endtask

    task automatic test_simultaneous();
        time t0, t2;
        do_reset();
        release_reset();
        new_stream();
        add_word(1'b1, 64'($urandom), 9);
        for (int f = 0; f < 4; f++) add_word(f[0], 64'($urandom), 32);
        add_word(1'b0, 64'($urandom), 4);
        build_expected(0);
        align(t0);
        t2 = t0 + 80 + 160 * (9 + 128 - 1);   // rise carrying the second right LSB
        fork
            play();
            begin
                #(t2 + 38 - $time);
                out_ready = 1'b1;
                #20;
                out_ready = 1'b0;
                #9;
                n_checks++;
                if (out_valid !== 1'b1) begin n_errors++; $display("FAIL simul_valid: got %b expected 1", out_valid); end
                n_checks++;
                if ({data_left, data_right} !== exp_q[1]) begin n_errors++; $display("FAIL simul_loaded: got %h expected %h", {data_left, data_right}, exp_q[1]); end
            end
        join
        idle();
        n_checks++;
        if (ovr_cnt !== 0) begin n_errors++; $display("FAIL simul_overrun: got %0d expected 0", ovr_cnt); end
        n_checks++;
        if (acc_q.size() !== 1 || acc_q[0] !== exp_q[0]) begin
            n_errors++;
            $display("FAIL simul_first: got %0d frames, first %h expected %h", acc_q.size(), (acc_q.size() > 0) ? acc_q[0] : 64'hx, exp_q[0]);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (acc_q.size() !== 2 || acc_q[1] !== exp_q[1]) begin
            n_errors++;
            $display("FAIL simul_second: got %0d frames, last %h expected %h", acc_q.size(), (acc_q.size() > 1) ? acc_q[1] : 64'hx, exp_q[1]);
        end
    endtask

    task automatic test_reset_mid();
        time t0;
        do_reset();
        release_reset();
        new_stream();
        add_word(1'b1, 64'($urandom), 7);
        for (int f = 0; f < 6; f++) add_word(f[0], 64'($urandom), 32);
        add_word(1'b0, 64'($urandom), 5);
        build_expected(82);   // slots after the reset; leftover of the cut word is the pre-lock run
        align(t0);
        fork
            play();
            begin
                #(t0 + 160 * 81 + 40 - $time);   // low phase of a slot 10 bits into the second left word
                n_checks++;
                if (out_valid !== 1'b1) begin n_errors++; $display("FAIL rmid_pre_valid: got %b expected 1", out_valid); end
                resetn = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                n_checks++;
                if (out_valid !== 1'b0 || overrun !== 1'b0) begin
                    n_errors++;
                    $display("FAIL rmid_ctrl: got valid=%b overrun=%b expected 0/0", out_valid, overrun);
                end
                n_checks++;
                if ({data_left, data_right} !== 64'h0) begin
                    n_errors++;
                    $display("FAIL rmid_data: got %h expected 0", {data_left, data_right});
                end
                acc_q.delete();
                ovr_cnt   = 0;
                resetn    = 1'b1;
                out_ready = 1'b1;
            end
        join
        idle();
        n_checks++;
        if (acc_q.size() !== 1) begin n_errors++; $display("FAIL rmid_count: got %0d expected 1", acc_q.size()); end
        n_checks++;
        if (acc_q.size() < 1 || exp_q.size() < 1 || acc_q[0] !== exp_q[0]) begin
            n_errors++;
            $display("FAIL rmid_frame: got %h expected %h", (acc_q.size() > 0) ? acc_q[0] : 64'hx, (exp_q.size() > 0) ? exp_q[0] : 64'hx);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 3; it++) begin
            do_reset();
            release_reset();
            out_ready = 1'b1;
            new_stream();
            add_word(1'b1, 64'($urandom), $urandom_range(1, 20));
            for (int f = 0; f < 6; f++) add_word(f[0], {$urandom, $urandom}, $urandom_range(16, 40));
            add_word(1'b0, 64'($urandom), 3);
            build_expected(0);
            play();
            idle();
            n_checks++;
            if (acc_q.size() !== exp_q.size()) begin
                n_errors++;
                $display("FAIL rand_count[%0d]: got %0d expected %0d", it, acc_q.size(), exp_q.size());
            end
            for (int k = 0; k < exp_q.size() && k < acc_q.size(); k++) begin
                n_checks++;
                if (acc_q[k] !== exp_q[k]) begin
                    n_errors++;
                    $display("FAIL rand_frame[%0d.%0d]: got %h expected %h", it, k, acc_q[k], exp_q[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_backpressure();
        test_short_words();
        test_long_words();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/i2s_target_receive.md
Name: i2s_target_receive

Overview:
- I2S receiver for target (slave) mode. An external master drives sck and ws; this block samples them with the system clk.
- Deserializes the stereo stream on sd into left/right words. Delivers one complete {left, right} frame per ws period on a valid/ready interface.
- It is the receiving end of the link driven by our i2s_controller-clocked transmit path (for example a codec or a second FPGA acting as master). It feeds the visualizer sample pipeline.

Parameters:
- DATA_WIDTH, 32, bits per delivered channel word.
- SYNC_STAGES, 2, flip-flop synchronizer depth on sck/ws/sd (minimum 2).

Ports:
- clk  in  1  system clock; must be at least 4x sck frequency.
- resetn  in  1  asynchronous, active-low reset.
- sck  in  1  external serial bit clock, asynchronous to clk.
- ws  in  1  external word select; 0 = left, 1 = right.
- sd  in  1  external serial data, MSB first, one-sck delay after ws edge (standard I2S).
- data_left  out  DATA_WIDTH  left word of the presented frame.
- data_right  out  DATA_WIDTH  right word of the presented frame.
- out_valid  out  1  frame is presented.
- out_ready  in  1  consumer accepts the frame.
- overrun  out  1  one-clk pulse when a completed frame is dropped.

Behaviour:
- Reset: all outputs 0, synchronizers 0, state UNLOCKED, bit counter 0, shift words 0. Reset asserted mid-operation discards everything, including a presented frame.
- Sampling:
  - sck, ws and sd each pass through SYNC_STAGES flops.
  - An sck rising edge is detected as synced sck = 1 with its previous value = 0.
  - On each detected rise, capture ws_s and sd_s. All word logic advances only on detected rises.
- Word boundary: at a rise where the captured ws differs from the ws captured at the previous rise.
  - The sd bit captured at that same rise is the LSB of the word just ending, and is written into it first.
  - The word then closes. The next rise carries the MSB of the new word.
- Bit placement:
  - A counter cnt runs from 0. A bit is written to word[DATA_WIDTH-1-cnt] only while cnt < DATA_WIDTH; cnt saturates at DATA_WIDTH.
  - Short words are left-justified with zeros in the LSBs. Long words are truncated, keeping the first DATA_WIDTH bits.
  - The working word is cleared and cnt is reset to 0 on word close.
- FSM:
  - UNLOCKED: words are discarded. A ws 1->0 boundary moves to LEFT.
  - LEFT: a 0->1 boundary latches the working word into left_hold and moves to RIGHT.
  - RIGHT: a 1->0 boundary completes the right word and forms frame {left_hold, right}, then moves to LEFT.
  - The partial frame preceding lock is never emitted.
- Output handshake:
  - A completed frame loads data_left/data_right and sets out_valid when the output register is free: out_valid = 0, or out_valid & out_ready on the same clk.
  - If out_valid = 1 and out_ready = 0 when a frame completes, the new frame is dropped, the presented frame stays stable, and overrun pulses for 1 clk.
  - When there is no new frame, out_valid & out_ready clears out_valid.
  - data_left/data_right are held, not cleared, after acceptance.
- Latency: out_valid rises 3 to 4 clk rising edges after the pin-level sck rise carrying the right-word LSB (SYNC_STAGES=2; the spread is due to synchronizer phase).
- Timing constraint: sck high and low phases are each at least 2 clk periods. Glitches shorter than that are not supported.

Decomposition:
- Shared package i2s_pkg: the DATA_WIDTH default, the WS_LEFT = 0 / WS_RIGHT = 1 constants, and the rx_state encoding (UNLOCKED, LEFT, RIGHT).
- One sub-module i2s_sync_edge: parameterized SYNC_STAGES synchronizer for sck/ws/sd, plus the sck rise-detect pulse. It is reused by future target-mode transmit.

Test Plan (clk 50 MHz, sck = clk/8, 32 sck per channel unless noted):
- Lock: start the stream mid-right-word, then send L=0xA5A50F0F, R=0x12345678 with out_ready=1 -> exactly one frame with those values; no frame for the pre-lock partial.
- Backpressure: out_ready=0 over two frames (L=0x11111111/R=0x22222222, then 0x33333333/0x44444444) -> the first frame is held stable and the second is dropped with a single overrun pulse. Raising out_ready then accepts the first frame and out_valid drops.
- Short words: 24 sck per channel, L=0xABCDEF, R=0x123456 -> data_left=0xABCDEF00, data_right=0x12345600.
- Long words: 40 sck per channel, L=0xDEADBEEF followed by 8 extra bits -> data_left=0xDEADBEEF (extra bits ignored).
- Simultaneous: out_ready pulses on the exact clk a new frame completes while a frame is valid -> the old frame is accepted, the new frame is loaded, out_valid stays 1, no overrun.
- Reset mid-operation: resetn low for 3 clk while out_valid=1 and mid-left-word -> all outputs 0; after release, the block relocks and the first emitted frame is the first full frame after the next ws 1->0.
